// File: rtl/bitfusion_pkg.sv
// Shared constants, FSM state type and product extension for the bitfusion
// partial-sum accumulator.
package bitfusion_pkg;

    localparam int PSUM_W    = 8;
    localparam int ACC_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Extends a product to the widest legal accumulator; callers keep the low ACC_W bits.
    function automatic logic [ACC_MAX_W-1:0] ext(input logic [PSUM_W-1:0] p,
                                                 input logic              signed_mode);
        ext = {{(ACC_MAX_W-PSUM_W){signed_mode & p[PSUM_W-1]}}, p};
    endfunction

endpackage

// File: rtl/bitfusion_psum_accum_if.sv
// Product-in / result-out handshake bundle of the partial-sum accumulator.
interface bitfusion_psum_accum_if #(parameter int ACC_W = 20);
    import bitfusion_pkg::*;

    logic [PSUM_W-1:0] psum;
    logic              psum_valid;
    logic              psum_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_valid;
    logic              acc_ready;

    modport master (
        output psum, psum_valid, acc_ready,
        input  psum_ready, acc_out, acc_valid
    );

    modport slave (
        input  psum, psum_valid, acc_ready,
        output psum_ready, acc_out, acc_valid
    );

endinterface

// File: rtl/bitfusion_psum_accum_sat_add.sv
// ACC_W adder with signed/unsigned overflow detection; clamps the result
// only when BF_ACC_SATURATE_EN is defined, otherwise wraps.
module bf_sat_add #(
    parameter int ACC_W = 20
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    input  logic             signed_mode_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

    logic [ACC_W:0] raw_s;

    assign raw_s = {1'b0, a_i} + {1'b0, b_i};

    // Overflow detection and optional clamping of the raw sum.
    always_comb begin
        if (signed_mode_i) begin
            ovf_o = (a_i[ACC_W-1] == b_i[ACC_W-1]) && (raw_s[ACC_W-1] != a_i[ACC_W-1]);
        end else begin
            ovf_o = raw_s[ACC_W];
        end
`ifdef BF_ACC_SATURATE_EN
        if (ovf_o) begin
            if (signed_mode_i) begin
                // Both operands share a sign on signed overflow; clamp toward it.
                sum_o = a_i[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                sum_o = {ACC_W{1'b1}};
            end
        end else begin
            sum_o = raw_s[ACC_W-1:0];
        end
`else
        sum_o = raw_s[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/bitfusion_psum_accum.sv
// Reduces a vector of 8-bit fused-multiplier products into an ACC_W sum and
// hands it downstream over valid/ready. Saturation: define BF_ACC_SATURATE_EN.
module bitfusion_psum_accum
    import bitfusion_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    input  logic                   s_mode,
    bitfusion_psum_accum_if.slave  bus,
    output logic                   busy,
    output logic                   sat
);

    state_e           state_q, state_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             s_mode_q, s_mode_d;
    logic             sat_q, sat_d;
    logic             psum_ready_q, acc_valid_q, busy_q;

    logic [ACC_MAX_W-1:0] ext_full_s;
    logic [ACC_W-1:0]     sum_s;
    logic                 ovf_s;
    logic                 hs_s;
    logic                 unused_ok_s;

    assign ext_full_s  = ext(bus.psum, s_mode_q);
    assign hs_s        = bus.psum_valid & psum_ready_q;
    assign unused_ok_s = ^{ovf_s, ext_full_s};

    bf_sat_add #(.ACC_W(ACC_W)) u_add (
        .a_i           (acc_q),
        .b_i           (ext_full_s[ACC_W-1:0]),
        .signed_mode_i (s_mode_q),
        .sum_o         (sum_s),
        .ovf_o         (ovf_s)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        s_mode_d = s_mode_q;
        sat_d    = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A zero length encodes the full 2^LEN_W vector.
                    if (len == {LEN_W{1'b0}}) begin
                        cnt_d = {1'b1, {LEN_W{1'b0}}};
                    end else begin
                        cnt_d = {1'b0, len};
                    end
                    s_mode_d = s_mode;
                    acc_d    = {ACC_W{1'b0}};
                    sat_d    = 1'b0;
                    state_d  = ST_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (hs_s) begin
                    acc_d = sum_s;
                    cnt_d = cnt_q - {{LEN_W{1'b0}}, 1'b1};
`ifdef BF_ACC_SATURATE_EN
                    sat_d = sat_q | ovf_s;
`else
                    sat_d = 1'b0;
`endif
                    if (cnt_q == {{LEN_W{1'b0}}, 1'b1}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_DONE: begin
                if (bus.acc_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {(LEN_W+1){1'b0}};
            acc_q        <= {ACC_W{1'b0}};
            s_mode_q     <= 1'b0;
            sat_q        <= 1'b0;
            psum_ready_q <= 1'b0;
            acc_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            s_mode_q     <= s_mode_d;
            sat_q        <= sat_d;
            psum_ready_q <= (state_d == ST_ACC);
            acc_valid_q  <= (state_d == ST_DONE);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign bus.psum_ready = psum_ready_q;
    assign bus.acc_valid  = acc_valid_q;
    assign bus.acc_out    = acc_q;
    assign busy           = busy_q;
    assign sat            = sat_q;

endmodule

// File: tb/tb_bitfusion_psum_accum.sv
// Directed, table-driven bench for bitfusion_psum_accum (ACC_W=20 and ACC_W=9 instances).
module tb_bitfusion_psum_accum;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start20 = 1'b0, s_mode20 = 1'b0, busy20, sat20;
    logic [7:0] len20 = 8'd0;
    logic       start9 = 1'b0, s_mode9 = 1'b0, busy9, sat9;
    logic [7:0] len9 = 8'd0;

    bitfusion_psum_accum_if #(.ACC_W(20)) bus20 ();
    bitfusion_psum_accum_if #(.ACC_W(9))  bus9 ();

    bitfusion_psum_accum #(.ACC_W(20), .LEN_W(8)) dut20 (
        .clk(clk), .rst_n(rst_n), .start(start20), .len(len20), .s_mode(s_mode20),
        .bus(bus20.slave), .busy(busy20), .sat(sat20)
    );

    bitfusion_psum_accum #(.ACC_W(9), .LEN_W(8)) dut9 (
        .clk(clk), .rst_n(rst_n), .start(start9), .len(len9), .s_mode(s_mode9),
        .bus(bus9.slave), .busy(busy9), .sat(sat9)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        s_mode;
        logic [7:0]  len;
        logic [7:0]  p [4];
        logic        gaps;
        int          hold;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic run_row(input vec_t v);
        start20  = 1'b1;
        len20    = v.len;
        s_mode20 = v.s_mode;
        @(negedge clk);
        start20  = 1'b0;
        len20    = 8'd0;
        s_mode20 = ~v.s_mode;
        check("busy_after_start", {31'd0, busy20}, 32'd1);
        for (int i = 0; i < int'(v.len); i++) begin
            check("psum_ready_acc", {31'd0, bus20.psum_ready}, 32'd1);
            bus20.psum       = v.p[i];
            bus20.psum_valid = 1'b1;
            @(negedge clk);
            bus20.psum_valid = 1'b0;
            if (v.gaps && (i < int'(v.len) - 1)) begin
                bus20.psum = 8'hAA;
                @(negedge clk);
            end
        end
        check("acc_valid_latency", {31'd0, bus20.acc_valid}, 32'd1);
        check("acc_out", {12'd0, bus20.acc_out}, {12'd0, v.exp});
        check("sat_row", {31'd0, sat20}, 32'd0);
        for (int h = 0; h < v.hold; h++) begin
            bus20.psum_valid = 1'b1;
            @(negedge clk);
            check("hold_acc_valid", {31'd0, bus20.acc_valid}, 32'd1);
            check("hold_acc_out", {12'd0, bus20.acc_out}, {12'd0, v.exp});
            check("hold_psum_ready", {31'd0, bus20.psum_ready}, 32'd0);
        end
        bus20.psum_valid = 1'b0;
        bus20.acc_ready  = 1'b1;
        @(negedge clk);
        bus20.acc_ready  = 1'b0;
        check("drain_acc_valid", {31'd0, bus20.acc_valid}, 32'd0);
        check("drain_busy", {31'd0, busy20}, 32'd0);
    endtask

    initial begin
        bus20.psum = 8'd0; bus20.psum_valid = 1'b0; bus20.acc_ready = 1'b0;
        bus9.psum  = 8'd0; bus9.psum_valid  = 1'b0; bus9.acc_ready  = 1'b0;

        vecs[0] = '{1'b0, 8'd3, '{8'd15, 8'd225, 8'd0, 8'd0},    1'b0, 0, 20'd240};
        vecs[1] = '{1'b1, 8'd4, '{8'hC8, 8'd64, 8'hFF, 8'd7},    1'b0, 5, 20'h0000E};
        vecs[2] = '{1'b0, 8'd3, '{8'd2, 8'd2, 8'd2, 8'd0},       1'b1, 0, 20'd6};
        vecs[3] = '{1'b1, 8'd2, '{8'h80, 8'h80, 8'd0, 8'd0},     1'b0, 1, 20'hFFF00};
        vecs[4] = '{1'b0, 8'd1, '{8'hFF, 8'd0, 8'd0, 8'd0},      1'b0, 0, 20'd255};
        vecs[5] = '{1'b1, 8'd3, '{8'hFF, 8'hFF, 8'hFF, 8'd0},    1'b1, 2, 20'hFFFFD};

        repeat (2) @(negedge clk);
        check("rst_psum_ready", {31'd0, bus20.psum_ready}, 32'd0);
        check("rst_acc_valid", {31'd0, bus20.acc_valid}, 32'd0);
        check("rst_busy", {31'd0, busy20}, 32'd0);
        check("rst_sat", {31'd0, sat20}, 32'd0);
        check("rst_acc_out", {12'd0, bus20.acc_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_start", {31'd0, busy20}, 32'd0);

        for (int r = 0; r < 6; r++) begin
            run_row(vecs[r]);
        end

        // Full-length vector (len=0 -> 256 products) with a stray start mid-vector.
        start20 = 1'b1; len20 = 8'd0; s_mode20 = 1'b0;
        @(negedge clk);
        start20 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (i == 10) begin
                start20 = 1'b1; len20 = 8'd3; s_mode20 = 1'b1;
            end else begin
                start20 = 1'b0;
            end
            if (i == 255) begin
                check("len0_ready_at_255", {31'd0, bus20.psum_ready}, 32'd1);
            end
            bus20.psum = 8'd225; bus20.psum_valid = 1'b1;
            @(negedge clk);
        end
        bus20.psum_valid = 1'b0; start20 = 1'b0;
        check("len0_acc_valid", {31'd0, bus20.acc_valid}, 32'd1);
        check("len0_acc_out", {12'd0, bus20.acc_out}, 32'd57600);
        bus20.acc_ready = 1'b1;
        @(negedge clk);
        bus20.acc_ready = 1'b0;
        check("len0_drain", {31'd0, bus20.acc_valid}, 32'd0);

        // Narrow accumulator overflow: 3 x 225 unsigned into 9 bits.
        start9 = 1'b1; len9 = 8'd3; s_mode9 = 1'b0;
        @(negedge clk);
        start9 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus9.psum = 8'd225; bus9.psum_valid = 1'b1;
            @(negedge clk);
        end
        bus9.psum_valid = 1'b0;
        check("w9_acc_valid", {31'd0, bus9.acc_valid}, 32'd1);
`ifdef BF_ACC_SATURATE_EN
        check("w9_acc_out", {23'd0, bus9.acc_out}, 32'd511);
        check("w9_sat", {31'd0, sat9}, 32'd1);
`else
        check("w9_acc_out", {23'd0, bus9.acc_out}, 32'd163);
        check("w9_sat", {31'd0, sat9}, 32'd0);
`endif
        bus9.acc_ready = 1'b1;
        @(negedge clk);
        bus9.acc_ready = 1'b0;
        check("w9_drain", {31'd0, bus9.acc_valid}, 32'd0);

        // Reset mid-vector: len=4, two products taken, then asynchronous abort.
        start20 = 1'b1; len20 = 8'd4; s_mode20 = 1'b0;
        @(negedge clk);
        start20 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus20.psum = 8'd9; bus20.psum_valid = 1'b1;
            @(negedge clk);
        end
        check("mid_busy", {31'd0, busy20}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_psum_ready", {31'd0, bus20.psum_ready}, 32'd0);
        check("arst_busy", {31'd0, busy20}, 32'd0);
        check("arst_acc_valid", {31'd0, bus20.acc_valid}, 32'd0);
        check("arst_acc_out", {12'd0, bus20.acc_out}, 32'd0);
        check("arst_sat", {31'd0, sat20}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", {31'd0, bus20.acc_valid}, 32'd0);
            check("post_rst_no_ready", {31'd0, bus20.psum_ready}, 32'd0);
        end
        bus20.psum_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bitfusion_psum_accum.md
# bitfusion_psum_accum

Downstream stage of the 4-bit fusible multiplier (`bitfusion_top`). It takes the 8-bit `psum` product stream and reduces one dot-product vector of configurable length into a wide accumulator. Each product is sign- or zero-extended according to the operand signedness. Completed sums are handed to the next stage over a valid/ready handshake, with backpressure on both sides.

## Interface
Parameters:
- `ACC_W`, default 20: accumulator and result width. Legal range is 9..32.
- `LEN_W`, default 8: width of the vector-length field.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: begin a vector. Sampled only in IDLE.
- `len` in LEN_W: number of products in the vector. 0 means 2^LEN_W. Latched on `start`.
- `s_mode` in 1: 1 means the product is signed (`s_in | s_weight` of the multiplier). Latched on `start`.
- `psum` in 8: product from the multiplier.
- `psum_valid` in 1: `psum` is valid this cycle.
- `psum_ready` out 1: the block accepts `psum` this cycle.
- `acc_out` out ACC_W: completed dot-product sum, two's complement when signed.
- `acc_valid` out 1: `acc_out` is valid.
- `acc_ready` in 1: the consumer takes `acc_out`.
- `busy` out 1: the FSM is not in IDLE.
- `sat` out 1: sticky saturation flag for the current vector.

## Operation
- FSM states are IDLE, ACC and DONE.
- **IDLE, start = 1:**
  - Load `cnt` = `len` (0 loads 2^LEN_W).
  - Latch `s_mode`; clear `acc`; clear `sat`.
  - Go to ACC.
- **IDLE, start = 0:** stay in IDLE.
- **ACC:**
  - `psum_ready` = 1.
  - On a handshake (`psum_valid & psum_ready`): `acc` = `acc` + ext(`psum`) and `cnt` = `cnt` − 1.
  - ext() is a sign-extension of `psum[7]` when the latched `s_mode` = 1, otherwise a zero-extension.
  - The handshake with `cnt` == 1 is the last one; go to DONE.
  - No handshake leaves `acc` and `cnt` unchanged.
- **DONE:**
  - `acc_valid` = 1 and `acc_out` = `acc`.
  - Both are held stable until `acc_ready` = 1, then go to IDLE.
- Outside IDLE:
  - `start` is ignored.
  - `len` and `s_mode` changes have no effect.
- Arithmetic: the adder is ACC_W bits wide. Overflow behaviour is set by the Configuration macro.
- `acc_out` is driven from the `acc` register at all times. It is only meaningful while `acc_valid` = 1.

## Timing
- Reset values: `psum_ready` = 0, `acc_valid` = 0, `busy` = 0, `sat` = 0, `acc_out` = 0. State is IDLE, `cnt` = 0.
- Asserting `rst_n` mid-vector aborts the vector immediately, asynchronously. No partial result is emitted.
- `start` seen at edge E puts the block in ACC after E. `psum_ready` = 1 from the cycle after `start`.
- Throughput is one product per cycle. `psum_valid` gaps stall accumulation without loss.
- Latency: the last handshake at edge N gives `acc_valid` = 1 in the cycle after N, with the final sum.
- `acc_valid` falls after the edge where `acc_ready` = 1. The earliest next `start` is sampled in the following (IDLE) cycle, so the minimum gap between vectors is 1 cycle.
- `psum_ready` = 0 in IDLE and DONE. Multiplier output is not consumed while a result awaits drain.
- `acc_ready` held high in DONE gives a 1-cycle DONE. `acc_ready` is ignored outside DONE.

## Configuration
- Macro: `BF_ACC_SATURATE_EN`.
- Defined:
  - On overflow, the sum clamps to the ACC_W range: signed [−2^(ACC_W−1), 2^(ACC_W−1)−1], or unsigned [0, 2^ACC_W−1].
  - `sat` sets and stays set until the next `start` or reset.
- Undefined:
  - The sum wraps modulo 2^ACC_W.
  - `sat` is constant 0.

## Structure
- Package `bitfusion_pkg` holds:
  - the `PSUM_W` = 8 constant;
  - the FSM state enum (IDLE/ACC/DONE);
  - the ext() function (sign/zero extension of `psum` to ACC_W).
- Sub-module `bf_sat_add`: an ACC_W adder with a signed/unsigned mode input, returning sum and overflow. Its clamping logic is present only under `BF_ACC_SATURATE_EN`.

## Test plan
- Reset mid-ACC: `len` = 4, 2 products accepted, `rst_n` pulsed low → all outputs return to reset values at once and no `acc_valid` follows.
- Unsigned: `s_mode` = 0, `len` = 3, psum 15, 225, 0 → `acc_valid` the cycle after the 3rd handshake, `acc_out` = 240.
- Signed: `s_mode` = 1, `len` = 4, psum 8'hC8 (−56), 64, 8'hFF (−1), 7 → `acc_out` = 14 (20'h0000E).
- Backpressure:
  - `psum_valid` toggled 1,0,1,0,1 with `len` = 3 of value 2 → `acc_out` = 6.
  - `acc_ready` held 0 for 5 cycles → `acc_out` is stable and `psum_ready` = 0 throughout.
- `len` = 0, all psum = 225 unsigned → 256 handshakes, `acc_out` = 57600. A `start` pulse during ACC is ignored.
- ACC_W = 9, unsigned, `len` = 3 of 225:
  - With the macro: `acc_out` = 511, `sat` = 1.
  - Without it: `acc_out` = 675 mod 512 = 163, `sat` = 0.
